// File: rtl/ntt_result_collector.sv
// Collects one bit-reversed NTT result frame, then replays it in natural order
// over a valid/ready handshake. Fill and drain never overlap (single buffer).
module ntt_result_collector #(
    parameter int W      = 32,
    parameter int N      = 8,
    parameter int LOGN   = 3,
    parameter int BITREV = 1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    input  logic [W-1:0] in_data,
    output logic         in_ready,
    output logic         out_valid,
    output logic [W-1:0] out_data,
    input  logic         out_ready,
    output logic         out_last,
    output logic         busy,
    output logic [7:0]   frame_cnt
);

    typedef enum logic [1:0] {IDLE, FILL, DRAIN} state_t;

    localparam logic [LOGN-1:0] LAST_IDX = LOGN'(N - 1);

    state_t          state_reg, state_next;
    logic [LOGN-1:0] wr_cnt_reg, wr_cnt_next;
    logic [LOGN-1:0] rd_cnt_reg, rd_cnt_next;
    logic [7:0]      frame_cnt_reg, frame_cnt_next;
    logic [LOGN-1:0] wr_cnt_rev;
    logic [LOGN-1:0] wr_addr;
    logic [W-1:0]    buf_reg [N];
    logic            accept;

    // Mirror the beat index to undo the core's bit-reversed output order.
    for (genvar gi = 0; gi < LOGN; gi++) begin : g_rev
        assign wr_cnt_rev[gi] = wr_cnt_reg[LOGN-1-gi];
    end

    assign wr_addr = (BITREV != 0) ? wr_cnt_rev : wr_cnt_reg;

    for (genvar gi = 0; gi < N; gi++) begin : g_buf
        always_ff @(posedge clk or negedge rst) begin
            if (!rst) begin
                buf_reg[gi] <= '0;
            end else if (accept && (wr_addr == LOGN'(gi))) begin
                buf_reg[gi] <= in_data;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg     <= IDLE;
            wr_cnt_reg    <= '0;
            rd_cnt_reg    <= '0;
            frame_cnt_reg <= '0;
        end else begin
            state_reg     <= state_next;
            wr_cnt_reg    <= wr_cnt_next;
            rd_cnt_reg    <= rd_cnt_next;
            frame_cnt_reg <= frame_cnt_next;
        end
    end

    always_comb begin
        state_next     = state_reg;
        wr_cnt_next    = wr_cnt_reg;
        rd_cnt_next    = rd_cnt_reg;
        frame_cnt_next = frame_cnt_reg;
        in_ready       = 1'b1;
        out_valid      = 1'b0;
        out_data       = '0;
        out_last       = 1'b0;
        busy           = 1'b0;
        accept         = 1'b0;

        case (state_reg)
            IDLE: begin
                accept = in_valid;
                if (accept) begin
                    wr_cnt_next = wr_cnt_reg + 1'b1;
                    state_next  = FILL;
                end
            end
            FILL: begin
                busy   = 1'b1;
                accept = in_valid;
                if (accept) begin
                    // Counter width is exactly LOGN, so N-1 + 1 wraps to 0.
                    wr_cnt_next = wr_cnt_reg + 1'b1;
                    if (wr_cnt_reg == LAST_IDX) begin
                        state_next = DRAIN;
                    end
                end
            end
            DRAIN: begin
                busy      = 1'b1;
                in_ready  = 1'b0;
                out_valid = 1'b1;
                out_data  = buf_reg[rd_cnt_reg];
                out_last  = (rd_cnt_reg == LAST_IDX);
                if (out_ready) begin
                    rd_cnt_next = rd_cnt_reg + 1'b1;
                    if (rd_cnt_reg == LAST_IDX) begin
                        state_next     = IDLE;
                        frame_cnt_next = frame_cnt_reg + 8'd1;
                    end
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    assign frame_cnt = frame_cnt_reg;

endmodule

// File: tb/tb_ntt_result_collector.sv
// Directed bench: bit-reversed and straight-order instances share one stimulus
// stream, so both always sit in the same state while outputs differ.
module tb_ntt_result_collector;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic [31:0] in_data;
    logic        out_ready;

    logic        rev_in_ready, rev_out_valid, rev_out_last, rev_busy;
    logic [31:0] rev_out_data;
    logic [7:0]  rev_frame_cnt;
    logic        nat_in_ready, nat_out_valid, nat_out_last, nat_busy;
    logic [31:0] nat_out_data;
    logic [7:0]  nat_frame_cnt;

    int n_checks = 0;
    int n_fail   = 0;
    int exp_frames = 0;

    logic [31:0] vin     [8] = '{32'd5569, 32'd3457, 32'd1345, 32'd6914,
                                 32'd4802, 32'd2690, 32'd578,  32'd6147};
    logic [31:0] exp_rev [8] = '{32'd5569, 32'd4802, 32'd1345, 32'd578,
                                 32'd3457, 32'd2690, 32'd6914, 32'd6147};

    ntt_result_collector #(.W(32), .N(8), .LOGN(3), .BITREV(1)) u_rev (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data),
        .in_ready(rev_in_ready), .out_valid(rev_out_valid), .out_data(rev_out_data),
        .out_ready(out_ready), .out_last(rev_out_last), .busy(rev_busy),
        .frame_cnt(rev_frame_cnt)
    );

    ntt_result_collector #(.W(32), .N(8), .LOGN(3), .BITREV(0)) u_nat (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data),
        .in_ready(nat_in_ready), .out_valid(nat_out_valid), .out_data(nat_out_data),
        .out_ready(out_ready), .out_last(nat_out_last), .busy(nat_busy),
        .frame_cnt(nat_frame_cnt)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

    // Presents the eight words of vin on consecutive cycles (no checking).
    task automatic feed_vin();
        for (int i = 0; i < 8; i++) begin
            in_valid = 1'b1;
            in_data  = vin[i];
            @(negedge clk);
        end
        in_valid = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b1;
        #2;
        n_checks++;
        if ({rev_in_ready, rev_out_valid, rev_out_last, rev_busy} !== 4'b1000)
            begin n_fail++; $display("FAIL reset_flags: got %b want 1000",
                {rev_in_ready, rev_out_valid, rev_out_last, rev_busy}); end
        @(negedge clk); @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        n_checks++;
        if (rev_out_data !== 32'd0 || rev_frame_cnt !== 8'd0 || nat_busy !== 1'b0)
            begin n_fail++; $display("FAIL reset_after: data=%0d frame_cnt=%0d busy=%b want 0 0 0",
                rev_out_data, rev_frame_cnt, nat_busy); end
        $display("test_reset done");
    endtask

    task automatic test_bitrev_frame();
        feed_vin();
        for (int j = 0; j < 8; j++) begin
            n_checks++;
            if (rev_out_valid !== 1'b1 || rev_out_data !== exp_rev[j] ||
                rev_out_last !== (j == 7))
                begin n_fail++; $display("FAIL bitrev_out[%0d]: valid=%b data=%0d last=%b want 1 %0d %b",
                    j, rev_out_valid, rev_out_data, rev_out_last, exp_rev[j], (j == 7)); end
            @(negedge clk);
        end
        exp_frames++;
        n_checks++;
        if (rev_busy !== 1'b0 || rev_out_valid !== 1'b0 || rev_frame_cnt !== 8'(exp_frames))
            begin n_fail++; $display("FAIL bitrev_end: busy=%b valid=%b frame_cnt=%0d want 0 0 %0d",
                rev_busy, rev_out_valid, rev_frame_cnt, exp_frames); end
        $display("test_bitrev_frame done");
    endtask

    task automatic test_straight_order();
        for (int i = 0; i < 8; i++) begin
            if (i == 7) begin
                n_checks++;
                if (nat_out_valid !== 1'b0)
                    begin n_fail++; $display("FAIL nat_early_valid: got %b want 0", nat_out_valid); end
            end
            in_valid = 1'b1;
            in_data  = vin[i];
            @(negedge clk);
        end
        in_valid = 1'b0;
        for (int j = 0; j < 8; j++) begin
            n_checks++;
            if (nat_out_valid !== 1'b1 || nat_out_data !== vin[j] || nat_out_last !== (j == 7))
                begin n_fail++; $display("FAIL nat_out[%0d]: valid=%b data=%0d last=%b want 1 %0d %b",
                    j, nat_out_valid, nat_out_data, nat_out_last, vin[j], (j == 7)); end
            @(negedge clk);
        end
        exp_frames++;
        n_checks++;
        if (nat_frame_cnt !== 8'(exp_frames) || nat_busy !== 1'b0)
            begin n_fail++; $display("FAIL nat_end: frame_cnt=%0d busy=%b want %0d 0",
                nat_frame_cnt, nat_busy, exp_frames); end
        $display("test_straight_order done");
    endtask

    task automatic test_gaps_backpressure();
        for (int i = 0; i < 8; i++) begin
            if (i > 0) begin
                in_valid = 1'b0;
                in_data  = 32'hDEAD_BEEF;
                @(negedge clk);
                n_checks++;
                if (rev_in_ready !== 1'b1 || rev_out_valid !== 1'b0)
                    begin n_fail++; $display("FAIL gap_fill[%0d]: in_ready=%b out_valid=%b want 1 0",
                        i, rev_in_ready, rev_out_valid); end
            end
            in_valid = 1'b1;
            in_data  = vin[i];
            @(negedge clk);
        end
        in_valid = 1'b0;
        for (int j = 0; j < 8; j++) begin
            if (j == 2) begin
                out_ready = 1'b0;
                for (int k = 0; k < 3; k++) begin
                    n_checks++;
                    if (rev_out_valid !== 1'b1 || rev_out_data !== 32'd1345)
                        begin n_fail++; $display("FAIL stall[%0d]: valid=%b data=%0d want 1 1345",
                            k, rev_out_valid, rev_out_data); end
                    @(negedge clk);
                end
                out_ready = 1'b1;
            end
            n_checks++;
            if (rev_out_valid !== 1'b1 || rev_out_data !== exp_rev[j] || rev_out_last !== (j == 7))
                begin n_fail++; $display("FAIL gap_out[%0d]: valid=%b data=%0d last=%b want 1 %0d %b",
                    j, rev_out_valid, rev_out_data, rev_out_last, exp_rev[j], (j == 7)); end
            @(negedge clk);
        end
        exp_frames++;
        n_checks++;
        if (rev_frame_cnt !== 8'(exp_frames))
            begin n_fail++; $display("FAIL gap_frames: got %0d want %0d", rev_frame_cnt, exp_frames); end
        $display("test_gaps_backpressure done");
    endtask

    task automatic test_drain_blocking();
        logic [31:0] exp_next [8];
        exp_next = exp_rev;
        exp_next[0] = 32'd99;
        feed_vin();
        in_valid = 1'b1;
        in_data  = 32'd99;
        for (int j = 0; j < 8; j++) begin
            n_checks++;
            if (rev_in_ready !== 1'b0 || rev_out_data !== exp_rev[j])
                begin n_fail++; $display("FAIL block_out[%0d]: in_ready=%b data=%0d want 0 %0d",
                    j, rev_in_ready, rev_out_data, exp_rev[j]); end
            @(negedge clk);
        end
        exp_frames++;
        n_checks++;
        if (rev_in_ready !== 1'b1 || rev_busy !== 1'b0)
            begin n_fail++; $display("FAIL block_idle: in_ready=%b busy=%b want 1 0",
                rev_in_ready, rev_busy); end
        @(negedge clk);
        for (int i = 1; i < 8; i++) begin
            in_data = vin[i];
            @(negedge clk);
        end
        in_valid = 1'b0;
        for (int j = 0; j < 8; j++) begin
            n_checks++;
            if (rev_out_valid !== 1'b1 || rev_out_data !== exp_next[j])
                begin n_fail++; $display("FAIL block_next[%0d]: valid=%b data=%0d want 1 %0d",
                    j, rev_out_valid, rev_out_data, exp_next[j]); end
            @(negedge clk);
        end
        exp_frames++;
        n_checks++;
        if (rev_frame_cnt !== 8'(exp_frames))
            begin n_fail++; $display("FAIL block_frames: got %0d want %0d", rev_frame_cnt, exp_frames); end
        $display("test_drain_blocking done");
    endtask

    task automatic test_mid_reset();
        logic [31:0] exp_seq [8] = '{32'd1, 32'd5, 32'd3, 32'd7, 32'd2, 32'd6, 32'd4, 32'd8};
        for (int i = 0; i < 5; i++) begin
            in_valid = 1'b1;
            in_data  = 32'd1000 + 32'(i);
            @(negedge clk);
        end
        in_valid = 1'b0;
        rst = 1'b0;
        #1;
        n_checks++;
        if (rev_busy !== 1'b0 || rev_frame_cnt !== 8'd0 || rev_in_ready !== 1'b1)
            begin n_fail++; $display("FAIL midrst_async: busy=%b frame_cnt=%0d in_ready=%b want 0 0 1",
                rev_busy, rev_frame_cnt, rev_in_ready); end
        @(negedge clk);
        rst = 1'b1;
        exp_frames = 0;
        for (int i = 0; i < 8; i++) begin
            in_valid = 1'b1;
            in_data  = 32'(i + 1);
            @(negedge clk);
        end
        in_valid = 1'b0;
        for (int j = 0; j < 8; j++) begin
            n_checks++;
            if (rev_out_valid !== 1'b1 || rev_out_data !== exp_seq[j])
                begin n_fail++; $display("FAIL midrst_out[%0d]: valid=%b data=%0d want 1 %0d",
                    j, rev_out_valid, rev_out_data, exp_seq[j]); end
            @(negedge clk);
        end
        exp_frames++;
        n_checks++;
        if (rev_frame_cnt !== 8'd1)
            begin n_fail++; $display("FAIL midrst_frames: got %0d want 1", rev_frame_cnt); end
        $display("test_mid_reset done");
    endtask

    task automatic test_frame_wrap();
        rst = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        for (int f = 1; f <= 256; f++) begin
            feed_vin();
            repeat (8) @(negedge clk);
            if (f == 255) begin
                n_checks++;
                if (rev_frame_cnt !== 8'd255)
                    begin n_fail++; $display("FAIL wrap_255: got %0d want 255", rev_frame_cnt); end
            end
        end
        n_checks++;
        if (rev_frame_cnt !== 8'd0 || rev_busy !== 1'b0)
            begin n_fail++; $display("FAIL wrap_256: frame_cnt=%0d busy=%b want 0 0",
                rev_frame_cnt, rev_busy); end
        $display("test_frame_wrap done");
    endtask

    initial begin
        test_reset();
        test_bitrev_frame();
        test_straight_order();
        test_gaps_backpressure();
        test_drain_blocking();
        test_mid_reset();
        test_frame_wrap();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/ntt_result_collector.md
Name: ntt_result_collector

Overview:
- Output-side companion to the NTT core. It captures the serial N-coefficient result stream (one W-bit word per accepted beat), undoes the core's bit-reversed output order, and replays the frame in natural order to a downstream consumer over a valid/ready handshake.
- It is the reverse of the serial coefficient loader that feeds the core, and sits between the core's result port and the host readback path.

Parameters:
- W, 32, coefficient width in bits
- N, 8, coefficients per frame; must be a power of 2 and at least 2
- LOGN, 3, log2(N), index width
- BITREV, 1, 1 = write address is bit-reversed beat index; 0 = straight pass-through order

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  asynchronous reset, active-low (0 = reset)
- in_valid  in  1  core result word valid
- in_data  in  W  core result word (the core's final_result)
- in_ready  out  1  collector can accept a word this cycle
- out_valid  out  1  out_data holds a valid natural-order coefficient
- out_data  out  W  coefficient at read index rd_cnt
- out_ready  in  1  consumer accepts out_data this cycle
- out_last  out  1  high with out_valid on coefficient index N-1
- busy  out  1  high in FILL or DRAIN
- frame_cnt  out  8  completed (fully drained) frames; wraps 255->0

Behaviour:
- Storage: N x W register buffer. Counters: wr_cnt [LOGN-1:0] and rd_cnt [LOGN-1:0]. FSM states: IDLE, FILL, DRAIN.
- Reset (rst=0, asynchronous): state=IDLE, wr_cnt=0, rd_cnt=0, all buffer entries=0, frame_cnt=0.
  - Outputs during and after reset: in_ready=1, out_valid=0, out_last=0, busy=0, out_data=0.
- Accept event: in_valid & in_ready at a rising edge.
  - Writes buf[addr]=in_data.
  - addr = bitrev(wr_cnt) when BITREV=1 (bits reversed within LOGN); addr = wr_cnt when BITREV=0.
  - wr_cnt then increments, wrapping at N.
- in_ready = 1 in IDLE and FILL; 0 in DRAIN.
  - in_valid while in_ready=0 is ignored; the upstream must hold the word.
- Transitions:
  - IDLE: an accept event moves to FILL. If N=... (N>=2, so the first word never completes a frame.)
  - FILL: the accept event with wr_cnt==N-1 moves to DRAIN, and wr_cnt wraps to 0. Other accepts stay in FILL. No accept leaves state unchanged (gaps allowed).
  - DRAIN: out_valid=1, out_data=buf[rd_cnt] (combinational read of registered storage), out_last=(rd_cnt==N-1).
    - out_valid & out_ready increments rd_cnt.
    - The transfer with rd_cnt==N-1 moves to IDLE, sets rd_cnt=0 and increments frame_cnt.
    - out_valid and out_data stay stable while out_ready=0.
- Outside DRAIN: out_valid=0, out_last=0, out_data=0.
- Latency: out_valid rises the cycle after the N-th input is accepted. With out_ready held at 1, a frame drains in exactly N cycles.
- Back-to-back frames: the core must stall while in_ready=0.
  - The first word of the next frame is accepted at the earliest one cycle after the last drain transfer, when state is IDLE.
  - There is no overlap between fill and drain (single buffer).
- Reset mid-FILL or mid-DRAIN: the partial frame is discarded, all state returns to reset values, and frame_cnt is cleared.
- Buffer entries are not cleared between frames. Every entry is overwritten each frame, so stale data is never visible.

Test Plan:
1. Basic bit-reversed frame.
   - Stimulus: BITREV=1, out_ready=1. Feed 5569, 3457, 1345, 6914, 4802, 2690, 578, 6147 on consecutive cycles.
   - Required response: out stream is 5569, 4802, 1345, 578, 3457, 2690, 6914, 6147.
   - out_last only on 6147; frame_cnt=1; busy low after the last transfer.
2. Straight order.
   - Stimulus: BITREV=0, same 8 inputs.
   - Required response: output identical to input order. First out_valid appears exactly 1 cycle after the 8th accept.
3. Gapped input and backpressure.
   - Stimulus: in_valid toggling 1/0 during the fill. out_ready low for 3 cycles on index 2.
   - Required response: out_data holds 1345 stable with out_valid=1 for those cycles; sequence otherwise as in test 1.
4. DRAIN blocking.
   - Stimulus: assert in_valid with value 99 during DRAIN.
   - Required response: in_ready=0, the word is not stored, the drained frame is unchanged. 99 is accepted as index 0 of the next frame once back in IDLE.
5. Mid-operation reset.
   - Stimulus: pulse rst=0 after 5 accepts, then feed a fresh 8-word frame 1..8.
   - Required response: output is 1, 5, 3, 7, 2, 6, 4, 8 with no residue from the aborted frame; frame_cnt=1.
6. Frame counter wrap.
   - Stimulus: run 256 complete frames.
   - Required response: frame_cnt reads 255 after frame 255 and 0 after frame 256.
